// File: rtl/state_sequencer.sv
// Instruction-cycle sequencer: fetch, decode-wait, execute states and HALT,
// with stall, illegal-opcode pulse and a retired-instruction counter.
module state_sequencer #(
    parameter int unsigned DECODE_WAIT = 2,
    parameter logic [7:0]  OP_END      = 8'd8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic [7:0]  opcode,
    output logic [5:0]  state,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam int unsigned CW = (DECODE_WAIT > 1) ? $clog2(DECODE_WAIT) : 1;

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_CLAC, S_LDAC1, S_LDAC2, S_LDAC3, S_STAC1, S_STAC2, S_STAC3,
        S_MVACR, S_MVRAC, S_ADD, S_MUL, S_HALT
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   count_q, count_d;
    logic [5:0]    state_q, state_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;
    logic          illegal_q, illegal_d;
    logic          hold;

    // DECODE and HALT present code 0 so the control unit issues no controls.
    function automatic logic [5:0] state_code(input fsm_t s);
        case (s)
            S_FETCH1: state_code = 6'd1;
            S_FETCH2: state_code = 6'd2;
            S_FETCH3: state_code = 6'd3;
            S_CLAC:   state_code = 6'd4;
            S_LDAC1:  state_code = 6'd5;
            S_LDAC2:  state_code = 6'd6;
            S_LDAC3:  state_code = 6'd7;
            S_STAC1:  state_code = 6'd8;
            S_STAC2:  state_code = 6'd9;
            S_STAC3:  state_code = 6'd10;
            S_MVACR:  state_code = 6'd11;
            S_MVRAC:  state_code = 6'd12;
            S_ADD:    state_code = 6'd13;
            S_MUL:    state_code = 6'd14;
            default:  state_code = 6'd0;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q     <= S_IDLE;
            cnt_q     <= '0;
            count_q   <= '0;
            state_q   <= '0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            state_q   <= state_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        illegal_d = 1'b0;
        hold      = stall && (fsm_q != S_IDLE) && (fsm_q != S_HALT);

        if (!hold) begin
            case (fsm_q)
                S_IDLE:   if (start) fsm_d = S_FETCH1;
                S_FETCH1: fsm_d = S_FETCH2;
                S_FETCH2: fsm_d = S_FETCH3;
                S_FETCH3: begin
                    fsm_d = S_DECODE;
                    cnt_d = CW'(DECODE_WAIT - 1);
                end
                S_DECODE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        case (opcode)
                            8'd1:    fsm_d = S_CLAC;
                            8'd2:    fsm_d = S_LDAC1;
                            8'd3:    fsm_d = S_STAC1;
                            8'd4:    fsm_d = S_MVACR;
                            8'd5:    fsm_d = S_MVRAC;
                            8'd6:    fsm_d = S_ADD;
                            8'd7:    fsm_d = S_MUL;
                            default: begin
                                if (opcode == OP_END) begin
                                    fsm_d   = S_HALT;
                                    count_d = count_q + 16'd1;
                                end else begin
                                    fsm_d     = S_FETCH1;
                                    illegal_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_LDAC1:  fsm_d = S_LDAC2;
                S_LDAC2:  fsm_d = S_LDAC3;
                S_STAC1:  fsm_d = S_STAC2;
                S_STAC2:  fsm_d = S_STAC3;
                S_CLAC, S_LDAC3, S_STAC3, S_MVACR, S_MVRAC, S_ADD, S_MUL: begin
                    fsm_d   = S_FETCH1;
                    count_d = count_q + 16'd1;
                end
                S_HALT:   fsm_d = S_HALT;
                default:  fsm_d = S_IDLE;
            endcase
        end

        state_d  = state_code(fsm_d);
        busy_d   = (fsm_d != S_IDLE) && (fsm_d != S_HALT);
        halted_d = (fsm_d == S_HALT);
    end

    assign state       = state_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule
